// File: rtl/tx_slot_sched_if.sv
// tx_slot_sched_if
// Bundles the two packetizer handshakes and the registered GMII transmit
// outputs of tx_slot_sched.
//   vid_req/vid_data/vid_last -> scheduler, vid_gnt <- scheduler (video packetizer)
//   aux_req/aux_data/aux_last -> scheduler, aux_gnt <- scheduler (audio/InfoFrame packetizer)
//   gmii_tx_en/gmii_txd/gmii_tx_er <- scheduler (to the GMII/PHY output stage)
// master: the packetizer/PHY side; slave: the scheduler.
interface tx_slot_sched_if;
    logic       vid_req;
    logic [7:0] vid_data;
    logic       vid_last;
    logic       vid_gnt;
    logic       aux_req;
    logic [7:0] aux_data;
    logic       aux_last;
    logic       aux_gnt;
    logic       gmii_tx_en;
    logic [7:0] gmii_txd;
    logic       gmii_tx_er;

    modport master (
        output vid_req, vid_data, vid_last,
        input  vid_gnt,
        output aux_req, aux_data, aux_last,
        input  aux_gnt,
        input  gmii_tx_en, gmii_txd, gmii_tx_er
    );

    modport slave (
        input  vid_req, vid_data, vid_last,
        output vid_gnt,
        input  aux_req, aux_data, aux_last,
        output aux_gnt,
        output gmii_tx_en, gmii_txd, gmii_tx_er
    );
endinterface

// File: rtl/tx_slot_sched.sv
// tx_slot_sched
// Shares one GMII transmit port between the video-line packetizer and the
// auxiliary packetizer. One complete frame is granted at a time, video has
// priority, and aux is forced through after AUX_MAX_SKIP video grants taken
// while aux was waiting. Frames longer than MAX_LEN are truncated (last byte
// flagged with gmii_tx_er, remainder discarded), and IFG_CYCLES idle cycles
// are enforced after every frame.
// Ports:
//   sys_clk  - 125 MHz transmit byte clock, all registers on rising edge
//   rstbtn   - synchronous active-high reset
//   en       - scheduler enable, sampled only while idle
//   bus      - slave side of tx_slot_sched_if (requester handshakes, GMII outputs)
//   abort    - one-cycle pulse, aligned with the gmii_tx_er byte of a truncated frame
//   pkt_cnt  - frames completed normally, wraps
//   err_cnt  - frames truncated, saturates at 255
module tx_slot_sched #(
    parameter int unsigned IFG_CYCLES   = 12,
    parameter int unsigned MAX_LEN      = 1526,
    parameter int unsigned AUX_MAX_SKIP = 4
) (
    input  logic               sys_clk,
    input  logic               rstbtn,
    input  logic               en,
    tx_slot_sched_if.slave     bus,
    output logic               abort,
    output logic [15:0]        pkt_cnt,
    output logic [7:0]         err_cnt
);

    typedef enum logic [2:0] {IDLE, GRANT, XFER, DRAIN, IFG} state_t;

    localparam logic [10:0] LAST_IDX = 11'(MAX_LEN - 1);
    localparam logic [7:0]  IFG_LAST = 8'(IFG_CYCLES - 1);
    localparam logic [3:0]  SKIP_MAX = 4'(AUX_MAX_SKIP);

    state_t      state_q, state_d;
    logic        sel_aux_q, sel_aux_d;
    logic [10:0] byte_cnt_q;
    logic [7:0]  ifg_cnt_q;
    logic [3:0]  skip_q;

    logic [7:0]  cur_data;
    logic        cur_last;
    logic        at_limit;
    logic        truncate;

    // Byte stream of the selected requester; at_limit marks the MAX_LEN-th byte.
    always_comb begin
        cur_data = sel_aux_q ? bus.aux_data : bus.vid_data;
        cur_last = sel_aux_q ? bus.aux_last : bus.vid_last;
        at_limit = (byte_cnt_q == LAST_IDX);
        truncate = (state_q == XFER) && at_limit && !cur_last;
    end

    always_comb begin
        state_d     = state_q;
        sel_aux_d   = sel_aux_q;
        bus.vid_gnt = 1'b0;
        bus.aux_gnt = 1'b0;
        case (state_q)
            IDLE: begin
                if (en && (bus.vid_req || bus.aux_req)) begin
                    sel_aux_d = bus.aux_req && (!bus.vid_req || (skip_q == SKIP_MAX));
                    state_d   = GRANT;
                end
            end
            GRANT: begin
                // Gated by reset so a grant is never seen while reset is held.
                bus.vid_gnt = !sel_aux_q && !rstbtn;
                bus.aux_gnt = sel_aux_q && !rstbtn;
                state_d     = XFER;
            end
            XFER: begin
                if (cur_last) begin
                    state_d = IFG;
                end else if (at_limit) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (cur_last) begin
                    state_d = IFG;
                end
            end
            IFG: begin
                if (ifg_cnt_q == IFG_LAST) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (rstbtn) begin
            state_q        <= IDLE;
            sel_aux_q      <= 1'b0;
            byte_cnt_q     <= '0;
            ifg_cnt_q      <= '0;
            skip_q         <= '0;
            bus.gmii_tx_en <= 1'b0;
            bus.gmii_txd   <= '0;
            bus.gmii_tx_er <= 1'b0;
            abort          <= 1'b0;
            pkt_cnt        <= '0;
            err_cnt        <= '0;
        end else begin
            state_q   <= state_d;
            sel_aux_q <= sel_aux_d;

            byte_cnt_q <= (state_q == XFER) ? byte_cnt_q + 11'd1 : '0;
            ifg_cnt_q  <= (state_q == IFG) ? ifg_cnt_q + 8'd1 : '0;

            // Skip count tracks video grants taken while aux waits; it
            // saturates at SKIP_MAX, where the next arbitration goes to aux.
            if (state_q == GRANT) begin
                if (sel_aux_q) begin
                    skip_q <= '0;
                end else if (bus.aux_req && (skip_q != SKIP_MAX)) begin
                    skip_q <= skip_q + 4'd1;
                end
            end

            bus.gmii_tx_en <= (state_q == XFER);
            bus.gmii_txd   <= (state_q == XFER) ? cur_data : '0;
            bus.gmii_tx_er <= truncate;
            abort          <= truncate;

            if ((state_q == XFER) && cur_last) begin
                pkt_cnt <= pkt_cnt + 16'd1;
            end
            if (truncate && (err_cnt != 8'hFF)) begin
                err_cnt <= err_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_tx_slot_sched.sv
// tb_tx_slot_sched
// Self-checking bench for tx_slot_sched. Requester agents replay queued
// frames (length, first-byte seed; byte i = seed + i). A frame-level model
// derives the expected grant order, output bytes, inter-frame gaps and
// counters from the scheduling rules; a negedge monitor scores the DUT.
module tb_tx_slot_sched;
    localparam int IFG = 12;
    localparam int ML  = 100;
    localparam int AMS = 4;

    logic        sys_clk = 1'b0;
    logic        rstbtn;
    logic        en;
    logic        abort;
    logic [15:0] pkt_cnt;
    logic [7:0]  err_cnt;

    tx_slot_sched_if bus();

    logic       dreq  [2];
    logic [7:0] ddata [2];
    logic       dlast [2];

    assign bus.vid_req  = dreq[0];
    assign bus.vid_data = ddata[0];
    assign bus.vid_last = dlast[0];
    assign bus.aux_req  = dreq[1];
    assign bus.aux_data = ddata[1];
    assign bus.aux_last = dlast[1];

    tx_slot_sched #(
        .IFG_CYCLES  (IFG),
        .MAX_LEN     (ML),
        .AUX_MAX_SKIP(AMS)
    ) dut (
        .sys_clk(sys_clk),
        .rstbtn (rstbtn),
        .en     (en),
        .bus    (bus),
        .abort  (abort),
        .pkt_cnt(pkt_cnt),
        .err_cnt(err_cnt)
    );

    always #5 sys_clk = ~sys_clk;

    int cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // Pending frames per requester
    int vq_len[$], vq_seed[$], aq_len[$], aq_seed[$];

    // Model outputs
    logic [8:0] exp_bytes[$];   // {tx_er, txd}
    int         exp_gnt[$];     // 0 = video, 1 = aux
    int         exp_gap[$];
    int         m_skip = 0, m_pkt = 0, m_err = 0, m_abort = 0;

    // Monitor state
    int   obs_gnt[$];
    int   abort_seen = 0;
    bit   sb_on = 1'b0;
    bit   have_prev = 1'b0;
    int   idle_cnt = 0;
    int   first_en_cyc = -1;
    int   start_cyc = 0;
    bit   prev_en = 1'b0;

    always @(negedge sys_clk) begin : monitor
        int g;
        int eg;
        logic [8:0] e;
        if (abort === 1'b1) abort_seen++;
        if (sb_on) begin
            if (bus.vid_gnt === 1'b1 || bus.aux_gnt === 1'b1) begin
                obs_gnt.push_back(bus.aux_gnt === 1'b1 ? 1 : 0);
                checks++;
                if (exp_gnt.size() == 0 || (bus.vid_gnt === 1'b1 && bus.aux_gnt === 1'b1)) begin
                    errors++;
                    $display("FAIL grant_unexpected: vid_gnt=%b aux_gnt=%b, required no grant", bus.vid_gnt, bus.aux_gnt);
                end else begin
                    g = exp_gnt.pop_front();
                    if ((g == 1) != (bus.aux_gnt === 1'b1)) begin
                        errors++;
                        $display("FAIL grant_order: got %s, required %s", (bus.aux_gnt === 1'b1) ? "aux" : "vid", (g == 1) ? "aux" : "vid");
                    end
                end
            end
            if (bus.gmii_tx_en === 1'b1) begin
                if (!prev_en) begin
                    if (!have_prev) begin
                        first_en_cyc = cyc;
                    end else begin
                        checks++;
                        if (exp_gap.size() == 0) begin
                            errors++;
                            $display("FAIL gap_unexpected: frame start after %0d idle cycles, required no frame", idle_cnt);
                        end else begin
                            eg = exp_gap.pop_front();
                            if (idle_cnt != eg) begin
                                errors++;
                                $display("FAIL ifg_gap: got %0d idle cycles, required %0d", idle_cnt, eg);
                            end
                        end
                    end
                    have_prev = 1'b1;
                    idle_cnt  = 0;
                end
                checks++;
                if (exp_bytes.size() == 0) begin
                    errors++;
                    $display("FAIL byte_unexpected: txd=%h tx_er=%b, required tx_en=0", bus.gmii_txd, bus.gmii_tx_er);
                end else begin
                    e = exp_bytes.pop_front();
                    if ({bus.gmii_tx_er, bus.gmii_txd} !== e) begin
                        errors++;
                        $display("FAIL tx_byte: got er=%b txd=%h, required er=%b txd=%h", bus.gmii_tx_er, bus.gmii_txd, e[8], e[7:0]);
                    end
                end
            end else begin
                idle_cnt++;
            end
        end
        prev_en = (bus.gmii_tx_en === 1'b1);
    end

    // Frame-level model: both requesters keep requesting while they have
    // frames queued, so arbitration only depends on which queues are non-empty.
    task automatic build_expected();
        int vi = 0, ai = 0, extra = 0, len = 0, seed = 0, src = 0;
        bit first = 1'b1;
        bit ap, vp;
        while (vi < vq_len.size() || ai < aq_len.size()) begin
            ap = (ai < aq_len.size());
            vp = (vi < vq_len.size());
            if (ap && (!vp || m_skip == AMS)) begin
                src = 1; len = aq_len[ai]; seed = aq_seed[ai]; ai++;
                m_skip = 0;
            end else begin
                src = 0; len = vq_len[vi]; seed = vq_seed[vi]; vi++;
                if (ap && m_skip < AMS) m_skip++;
            end
            exp_gnt.push_back(src);
            for (int i = 0; i < len && i < ML; i++)
                exp_bytes.push_back({1'((i == ML - 1) && (len > ML)), 8'(seed + i)});
            if (!first) exp_gap.push_back(IFG + 2 + extra);
            first = 1'b0;
            extra = (len > ML) ? len - ML : 0;
            if (len > ML) begin
                m_abort++;
                if (m_err < 255) m_err++;
            end else begin
                m_pkt++;
            end
        end
    endtask

    task automatic agent(input int src);
        int len, seed, w;
        while (((src == 0) ? vq_len.size() : aq_len.size()) > 0) begin
            dreq[src] = 1'b1;
            w = 0;
            while (((src == 0) ? bus.vid_gnt : bus.aux_gnt) !== 1'b1 && w < 3000) begin
                @(posedge sys_clk); #1;
                w++;
            end
            checks++;
            if (w >= 3000) begin
                errors++;
                $display("FAIL grant_timeout: src=%0d no grant after %0d cycles, required a grant", src, w);
                dreq[src] = 1'b0;
                if (src == 0) begin vq_len.delete(); vq_seed.delete(); end
                else begin aq_len.delete(); aq_seed.delete(); end
                return;
            end
            if (src == 0) begin len = vq_len.pop_front(); seed = vq_seed.pop_front(); end
            else begin len = aq_len.pop_front(); seed = aq_seed.pop_front(); end
            dreq[src] = 1'b0;
            for (int i = 0; i < len; i++) begin
                @(posedge sys_clk); #1;
                ddata[src] = 8'(seed + i);
                dlast[src] = (i == len - 1);
            end
            @(posedge sys_clk); #1;
            ddata[src] = '0;
            dlast[src] = 1'b0;
        end
    endtask

    task automatic run_traffic();
        build_expected();
        obs_gnt.delete();
        have_prev    = 1'b0;
        first_en_cyc = -1;
        @(posedge sys_clk); #1;
        start_cyc = cyc;
        fork
            agent(0);
            agent(1);
        join
        repeat (IFG + 4) @(posedge sys_clk);
        #1;
    endtask

    task automatic test_reset();
        sb_on  = 1'b0;
        en     = 1'b0;
        rstbtn = 1'b1;
        for (int i = 0; i < 2; i++) begin dreq[i] = 1'b0; ddata[i] = '0; dlast[i] = 1'b0; end
        repeat (3) @(posedge sys_clk);
        @(negedge sys_clk);
        checks++; if (bus.gmii_tx_en !== 1'b0) begin errors++; $display("FAIL reset_tx_en: got %b, required 0", bus.gmii_tx_en); end
        checks++; if (bus.gmii_txd !== 8'h00) begin errors++; $display("FAIL reset_txd: got %h, required 00", bus.gmii_txd); end
        checks++; if (bus.gmii_tx_er !== 1'b0) begin errors++; $display("FAIL reset_tx_er: got %b, required 0", bus.gmii_tx_er); end
        checks++; if (abort !== 1'b0) begin errors++; $display("FAIL reset_abort: got %b, required 0", abort); end
        checks++; if (pkt_cnt !== 16'd0) begin errors++; $display("FAIL reset_pkt_cnt: got %0d, required 0", pkt_cnt); end
        checks++; if (err_cnt !== 8'd0) begin errors++; $display("FAIL reset_err_cnt: got %0d, required 0", err_cnt); end
        checks++; if ({bus.vid_gnt, bus.aux_gnt} !== 2'b00) begin errors++; $display("FAIL reset_gnt: got %b%b, required 00", bus.vid_gnt, bus.aux_gnt); end
        @(posedge sys_clk); #1;
        rstbtn = 1'b0;
        en     = 1'b1;
        sb_on  = 1'b1;
    endtask

    task automatic test_single();
        vq_len.push_back(64); vq_seed.push_back(0);
        run_traffic();
        checks++; if (first_en_cyc - start_cyc != 3) begin errors++; $display("FAIL single_latency: got %0d cycles, required 3", first_en_cyc - start_cyc); end
        checks++; if (exp_bytes.size() + exp_gnt.size() + exp_gap.size() != 0) begin errors++; $display("FAIL single_missing: got %0d outstanding items, required 0", exp_bytes.size() + exp_gnt.size() + exp_gap.size()); end
        checks++; if (pkt_cnt !== 16'd1) begin errors++; $display("FAIL single_pkt_cnt: got %0d, required 1", pkt_cnt); end
        checks++; if (err_cnt !== 8'd0) begin errors++; $display("FAIL single_err_cnt: got %0d, required 0", err_cnt); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 3; i++) begin vq_len.push_back(60); vq_seed.push_back(int'($urandom_range(0, 255))); end
        run_traffic();
        checks++; if (exp_bytes.size() + exp_gnt.size() + exp_gap.size() != 0) begin errors++; $display("FAIL b2b_missing: got %0d outstanding items, required 0", exp_bytes.size() + exp_gnt.size() + exp_gap.size()); end
        checks++; if (pkt_cnt !== 16'(m_pkt)) begin errors++; $display("FAIL b2b_pkt_cnt: got %0d, required %0d", pkt_cnt, m_pkt); end
        checks++; if (abort_seen != m_abort) begin errors++; $display("FAIL b2b_abort: got %0d pulses, required %0d", abort_seen, m_abort); end
    endtask

    task automatic test_starvation();
        int pat [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
        for (int i = 0; i < 8; i++) begin vq_len.push_back(int'($urandom_range(4, 16))); vq_seed.push_back(int'($urandom)); end
        for (int i = 0; i < 2; i++) begin aq_len.push_back(int'($urandom_range(4, 16))); aq_seed.push_back(int'($urandom)); end
        run_traffic();
        checks++; if (obs_gnt.size() != 10) begin errors++; $display("FAIL starve_grant_count: got %0d grants, required 10", obs_gnt.size()); end
        for (int i = 0; i < 10 && i < obs_gnt.size(); i++) begin
            checks++;
            if (obs_gnt[i] != pat[i]) begin errors++; $display("FAIL starve_order: grant %0d got %0d, required %0d (0=vid 1=aux)", i, obs_gnt[i], pat[i]); end
        end
        checks++; if (exp_bytes.size() + exp_gnt.size() + exp_gap.size() != 0) begin errors++; $display("FAIL starve_missing: got %0d outstanding items, required 0", exp_bytes.size() + exp_gnt.size() + exp_gap.size()); end
        checks++; if (pkt_cnt !== 16'(m_pkt)) begin errors++; $display("FAIL starve_pkt_cnt: got %0d, required %0d", pkt_cnt, m_pkt); end
    endtask

    task automatic test_max_len();
        int err0 = m_err;
        vq_len.push_back(150);    vq_seed.push_back(int'($urandom));
        vq_len.push_back(ML);     vq_seed.push_back(int'($urandom));
        vq_len.push_back(10);     vq_seed.push_back(int'($urandom));
        run_traffic();
        checks++; if (exp_bytes.size() + exp_gnt.size() + exp_gap.size() != 0) begin errors++; $display("FAIL maxlen_missing: got %0d outstanding items, required 0", exp_bytes.size() + exp_gnt.size() + exp_gap.size()); end
        checks++; if (err_cnt !== 8'(err0 + 1)) begin errors++; $display("FAIL maxlen_err_cnt: got %0d, required %0d", err_cnt, err0 + 1); end
        checks++; if (abort_seen != m_abort) begin errors++; $display("FAIL maxlen_abort: got %0d pulses, required %0d", abort_seen, m_abort); end
        checks++; if (pkt_cnt !== 16'(m_pkt)) begin errors++; $display("FAIL maxlen_pkt_cnt: got %0d, required %0d", pkt_cnt, m_pkt); end
    endtask

    task automatic test_enable();
        int  gcount = 0;
        bit  got = 1'b0;
        en = 1'b0;
        vq_len.push_back(20); vq_seed.push_back(int'($urandom));
        aq_len.push_back(15); aq_seed.push_back(int'($urandom));
        build_expected();
        have_prev = 1'b0;
        @(posedge sys_clk); #1;
        fork
            agent(0);
            agent(1);
            begin
                repeat (100) begin
                    @(negedge sys_clk);
                    if (bus.vid_gnt === 1'b1 || bus.aux_gnt === 1'b1) gcount++;
                end
                checks++; if (gcount != 0) begin errors++; $display("FAIL en_low_grant: got %0d grant cycles, required 0", gcount); end
                @(posedge sys_clk); #1;
                en = 1'b1;
                for (int i = 0; i < 2 && !got; i++) begin
                    @(negedge sys_clk);
                    if (bus.vid_gnt === 1'b1 || bus.aux_gnt === 1'b1) got = 1'b1;
                end
                checks++; if (!got) begin errors++; $display("FAIL en_rise_grant: got no grant within 2 cycles, required a grant"); end
            end
        join
        repeat (IFG + 4) @(posedge sys_clk);
        #1;
        checks++; if (exp_bytes.size() + exp_gnt.size() + exp_gap.size() != 0) begin errors++; $display("FAIL en_missing: got %0d outstanding items, required 0", exp_bytes.size() + exp_gnt.size() + exp_gap.size()); end
        checks++; if (pkt_cnt !== 16'(m_pkt)) begin errors++; $display("FAIL en_pkt_cnt: got %0d, required %0d", pkt_cnt, m_pkt); end
    endtask

    task automatic test_random();
        int nv, na;
        for (int it = 0; it < 4; it++) begin
            nv = int'($urandom_range(0, 4));
            na = int'($urandom_range(0, 3));
            if (nv + na == 0) nv = 1;
            for (int i = 0; i < nv; i++) begin vq_len.push_back(int'($urandom_range(1, 130))); vq_seed.push_back(int'($urandom)); end
            for (int i = 0; i < na; i++) begin aq_len.push_back(int'($urandom_range(1, 130))); aq_seed.push_back(int'($urandom)); end
            run_traffic();
            checks++; if (exp_bytes.size() + exp_gnt.size() + exp_gap.size() != 0) begin errors++; $display("FAIL rand_missing: iter %0d got %0d outstanding items, required 0", it, exp_bytes.size() + exp_gnt.size() + exp_gap.size()); end
            checks++; if (pkt_cnt !== 16'(m_pkt)) begin errors++; $display("FAIL rand_pkt_cnt: iter %0d got %0d, required %0d", it, pkt_cnt, m_pkt); end
            checks++; if (err_cnt !== 8'(m_err)) begin errors++; $display("FAIL rand_err_cnt: iter %0d got %0d, required %0d", it, err_cnt, m_err); end
            checks++; if (abort_seen != m_abort) begin errors++; $display("FAIL rand_abort: iter %0d got %0d pulses, required %0d", it, abort_seen, m_abort); end
        end
    endtask

    task automatic test_reset_mid_frame();
        int w = 0;
        int bad = 0;
        sb_on = 1'b0;
        @(posedge sys_clk); #1;
        dreq[0] = 1'b1;
        while (bus.vid_gnt !== 1'b1 && w < 100) begin @(posedge sys_clk); #1; w++; end
        checks++; if (w >= 100) begin errors++; $display("FAIL rst_pre_grant: got no grant in %0d cycles, required a grant", w); end
        dreq[0] = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge sys_clk); #1;
            ddata[0] = 8'(i);
            dlast[0] = 1'b0;
        end
        rstbtn  = 1'b1;
        dreq[0] = 1'b1;
        dreq[1] = 1'b1;
        @(negedge sys_clk);
        checks++; if (bus.gmii_tx_en !== 1'b1) begin errors++; $display("FAIL rst_pre_tx_en: got %b, required 1", bus.gmii_tx_en); end
        @(negedge sys_clk);
        checks++; if (bus.gmii_tx_en !== 1'b0) begin errors++; $display("FAIL rst_tx_en: got %b, required 0", bus.gmii_tx_en); end
        checks++; if (pkt_cnt !== 16'd0 || err_cnt !== 8'd0) begin errors++; $display("FAIL rst_counters: got pkt=%0d err=%0d, required 0 0", pkt_cnt, err_cnt); end
        repeat (3) begin
            @(negedge sys_clk);
            if (bus.vid_gnt === 1'b1 || bus.aux_gnt === 1'b1) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL rst_grant: got %0d grant cycles during reset, required 0", bad); end
        @(posedge sys_clk); #1;
        rstbtn = 1'b0;
        for (int i = 0; i < 2; i++) begin dreq[i] = 1'b0; ddata[i] = '0; dlast[i] = 1'b0; end
        m_skip = 0; m_pkt = 0; m_err = 0; m_abort = 0; abort_seen = 0;
        repeat (2) @(posedge sys_clk);
        sb_on = 1'b1;
        vq_len.push_back(30); vq_seed.push_back(int'($urandom));
        run_traffic();
        checks++; if (exp_bytes.size() + exp_gnt.size() + exp_gap.size() != 0) begin errors++; $display("FAIL rst_fresh_missing: got %0d outstanding items, required 0", exp_bytes.size() + exp_gnt.size() + exp_gap.size()); end
        checks++; if (pkt_cnt !== 16'd1) begin errors++; $display("FAIL rst_fresh_pkt_cnt: got %0d, required 1", pkt_cnt); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_starvation();
        test_max_len();
        test_enable();
        test_random();
        test_reset_mid_frame();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/tx_slot_sched.md
# tx_slot_sched

Packet scheduler sharing one GMII transmit port between the video-line packetizer and the auxiliary (audio/InfoFrame) packetizer in the HDMI-over-Ethernet transmit path. It grants one complete frame at a time and gives video priority, with a bounded-starvation guarantee for aux. It enforces the inter-frame gap and a maximum frame length, and registers the GMII outputs. It sits between the two packetizers and the GMII/PHY output stage, and is enabled from a board switch through the evaluation top.

## Interface
- IFG_CYCLES, 12: idle cycles forced between frames (1..255).
- MAX_LEN, 1526: maximum bytes per frame, preamble and FCS included (1..2047).
- AUX_MAX_SKIP, 4: video grants allowed while aux is pending before aux is forced to win (1..15).

- sys_clk  in  1  transmit byte clock (125 MHz); every register is clocked on its rising edge.
- rstbtn  in  1  reset; synchronous and active-high.
- en  in  1  scheduler enable; when low, no new grants are issued.
- vid_req  in  1  video frame ready; held until granted.
- vid_data  in  8  video frame byte.
- vid_last  in  1  marks the final video byte.
- vid_gnt  out  1  one-cycle video grant.
- aux_req, aux_data[7:0], aux_last, aux_gnt: same as the video group, for aux.
- gmii_tx_en  out  1  registered transmit enable.
- gmii_txd  out  8  registered transmit data.
- gmii_tx_er  out  1  registered transmit error.
- abort  out  1  one-cycle pulse when a frame is truncated.
- pkt_cnt  out  16  frames completed; wraps.
- err_cnt  out  8  frames aborted; saturates at 255.

## Operation
- States: IDLE, GRANT, XFER, DRAIN, IFG.
- IDLE:
  - If en=1 and any req is high, select a winner and go to GRANT.
  - Winner is aux when aux_req=1 and (vid_req=0 or skip==AUX_MAX_SKIP). Otherwise the winner is video.
- GRANT: the winner's gnt is high for exactly this one cycle, then the state goes to XFER.
- Requester contract:
  - The first byte is driven in the cycle after gnt.
  - One byte is driven every cycle with no bubbles, through the byte carrying last=1.
- XFER:
  - Each cycle, the selected data is registered into gmii_txd with gmii_tx_en=1 the next cycle.
  - A byte counter (11 bits) increments per accepted byte.
  - last=1 ends the frame: pkt_cnt increments and the state goes to IFG.
- Length limit: when the MAX_LEN-th byte is accepted with last=0:
  - That byte is output with gmii_tx_er=1.
  - abort pulses and err_cnt increments (saturating).
  - The state goes to DRAIN.
  - If last=1 on that same byte, the frame completes normally with no abort.
- DRAIN:
  - The requester's bytes are discarded and gmii_tx_en=0.
  - When the requester's last is seen, the state goes to IFG.
- IFG: counts IFG_CYCLES cycles with gmii_tx_en=0, then returns to IDLE.
- Skip counter (4 bits):
  - Increments on each video grant issued while aux_req=1.
  - Clears on each aux grant.
  - Never exceeds AUX_MAX_SKIP.
- en is sampled only in IDLE. Deasserting en mid-frame lets the current frame and its IFG finish.
- Unused data inputs and the req of the non-selected requester are ignored outside their grant.

## Timing
- Reset values: state=IDLE, every output 0, gmii_txd=0, pkt_cnt=0, err_cnt=0, skip=0, byte counter=0.
- Reset mid-frame: gmii_tx_en=0 from the cycle after reset is sampled, and no gnt is issued while rstbtn=1.
- Latency to first output byte: req sampled in IDLE at cycle 0, gnt at cycle 1, first byte presented at cycle 2, gmii_tx_en=1 at cycle 3.
- Output pipeline: fixed 1-cycle latency from requester byte to gmii_txd. gmii_tx_en falls the cycle after the last byte's output cycle.
- Frame-to-frame spacing:
  - Minimum idle on gmii_tx_en between frames is IFG_CYCLES+2 cycles, counted as IFG plus IDLE plus GRANT, so the next first byte appears two cycles after the IFG count ends.
  - IFG_CYCLES is the minimum guaranteed gap.
- Simultaneous vid_req and aux_req in IDLE: the skip rule decides the winner. There is no other tie-break.
- pkt_cnt wraps from 65535 to 0.

## Test plan
- Single video frame of 64 bytes (values 0x00..0x3F), IFG_CYCLES=12: vid_gnt pulses once, gmii_tx_en is high for exactly 64 cycles starting 3 cycles after req, gmii_txd is 0x00..0x3F in order, and pkt_cnt=1.
- Back-to-back video frames of 60 bytes: the idle gap on gmii_tx_en is 14 cycles and there is no tx_er.
- aux_req held high while video requests continuously, AUX_MAX_SKIP=4: the grant order is V,V,V,V,A,V,V,V,V,A, and skip returns to 0 after each aux grant.
- MAX_LEN=100 with a video frame of 150 bytes: the 100th byte is output with gmii_tx_er=1, abort pulses once, err_cnt=1, the remaining 50 bytes never appear, and IFG starts after byte 150.
- A frame of exactly MAX_LEN bytes ending in last: it completes normally with no abort and err_cnt unchanged.
- rstbtn asserted at byte 20 of a frame: gmii_tx_en=0 on the next cycle, all counters read 0, and a fresh req afterwards is granted normally.
- en=0 with both reqs high: no gnt for 100 cycles. Raising en produces a grant within 2 cycles.
